// File: rtl/uart_rx_if.sv
// MMIO bus bundle for the UART receiver: device select, register offset,
// read/write strobes and the registered read-data return path.
interface uart_rx_if;
    logic [2:0]  device_select;
    logic [15:0] mmio_addr;
    logic [7:0]  mmio_data_in;
    logic        mmio_wr;
    logic        mmio_rd;
    logic [7:0]  mmio_data_out;

    modport master (
        output device_select, mmio_addr, mmio_data_in, mmio_wr, mmio_rd,
        input  mmio_data_out
    );

    modport slave (
        input  device_select, mmio_addr, mmio_data_in, mmio_wr, mmio_rd,
        output mmio_data_out
    );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver with an MMIO register file (CR, SR, CDIV_H/L, DI) and a
// small receive FIFO. The serial line is double-synchronized before use.
module uart_rx #(
    parameter logic [2:0]  device_address = 3'b100,
    parameter int unsigned FIFO_DEPTH     = 4
) (
    input  logic     clk,
    input  logic     rst_n,
    uart_rx_if.slave bus,
    input  logic     rx
);
    localparam int unsigned   AW    = $clog2(FIFO_DEPTH);
    localparam logic [AW:0]   DEPTH = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t      state, state_n;
    logic [16:0] cnt, cnt_n;
    logic [2:0]  idx, idx_n;
    logic [7:0]  shreg, shreg_n;
    logic        push_req, fe_set;

    logic        rxe, ovr, fe;
    logic [7:0]  cdiv_h, cdiv_l;
    logic        sync1, sync2, rx_prev;

    logic [7:0]  mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr, rd_ptr, count;

    logic [15:0] cdiv;
    logic [16:0] period, half;
    logic        line_en, expire;
    logic        sel, wr_sel, rd_sel, wr_sr, flush;
    logic        rxne, full, pop, push_ok, ovr_set;

    assign cdiv    = {cdiv_h, cdiv_l};
    assign period  = {1'b0, cdiv} + 17'd1;
    assign half    = {2'b00, cdiv[15:1]};
    assign line_en = rxe && (cdiv >= 16'd3);
    assign expire  = (cnt <= 17'd1);

    assign sel    = (bus.device_select == device_address);
    assign wr_sel = sel && bus.mmio_wr;
    assign rd_sel = sel && bus.mmio_rd;
    assign wr_sr  = wr_sel && (bus.mmio_addr == 16'h0001);
    assign flush  = wr_sel && (bus.mmio_addr == 16'h0000) && bus.mmio_data_in[1];

    assign count   = wr_ptr - rd_ptr;
    assign rxne    = (count != '0);
    assign full    = (count == DEPTH);
    assign pop     = rd_sel && (bus.mmio_addr == 16'h0004) && rxne;
    // A pop in the same cycle frees the slot the incoming byte needs.
    assign push_ok = push_req && !flush && (!full || pop);
    assign ovr_set = push_req && !flush && full && !pop;

    // Two-flop synchronizer plus one history flop for start-edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1   <= 1'b1;
            sync2   <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            sync1   <= rx;
            sync2   <= sync1;
            rx_prev <= sync2;
        end
    end

    // Receiver state, bit counter, bit index and shift register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            idx   <= '0;
            shreg <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            idx   <= idx_n;
            shreg <= shreg_n;
        end
    end

    // Frame sequencing: half-period start check, full-period data/stop samples.
    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        idx_n    = idx;
        shreg_n  = shreg;
        push_req = 1'b0;
        fe_set   = 1'b0;
        if (!line_en) begin
            state_n = IDLE;
            cnt_n   = '0;
            idx_n   = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (rx_prev && !sync2) begin
                        state_n = START;
                        cnt_n   = half;
                    end
                end
                START: begin
                    if (!expire) begin
                        cnt_n = cnt - 17'd1;
                    end else if (!sync2) begin
                        state_n = DATA;
                        cnt_n   = period;
                        idx_n   = '0;
                    end else begin
                        state_n = IDLE;
                        cnt_n   = '0;
                    end
                end
                DATA: begin
                    if (!expire) begin
                        cnt_n = cnt - 17'd1;
                    end else begin
                        shreg_n[idx] = sync2;
                        cnt_n        = period;
                        if (idx == 3'd7) state_n = STOP;
                        else             idx_n   = idx + 3'd1;
                    end
                end
                STOP: begin
                    if (!expire) begin
                        cnt_n = cnt - 17'd1;
                    end else begin
                        if (sync2) push_req = 1'b1;
                        else       fe_set   = 1'b1;
                        state_n = IDLE;
                        cnt_n   = '0;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    // Control, divider and sticky status flags; a set event beats W1C.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rxe    <= 1'b0;
            cdiv_h <= '0;
            cdiv_l <= '0;
            ovr    <= 1'b0;
            fe     <= 1'b0;
        end else begin
            if (wr_sel && bus.mmio_addr == 16'h0000) rxe    <= bus.mmio_data_in[0];
            if (wr_sel && bus.mmio_addr == 16'h0002) cdiv_h <= bus.mmio_data_in;
            if (wr_sel && bus.mmio_addr == 16'h0003) cdiv_l <= bus.mmio_data_in;
            ovr <= ovr_set | (ovr & ~(wr_sr & bus.mmio_data_in[1]));
            fe  <= fe_set  | (fe  & ~(wr_sr & bus.mmio_data_in[2]));
        end
    end

    // FIFO pointers; flush discards everything including a same-cycle push.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            rd_ptr <= wr_ptr;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // FIFO storage; validity is tracked by the pointers only.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr[AW-1:0]] <= shreg;
    end

    // Registered read data; unmapped offsets and idle cycles hold the value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.mmio_data_out <= '0;
        end else if (rd_sel) begin
            case (bus.mmio_addr)
                16'h0000: bus.mmio_data_out <= {7'b0, rxe};
                16'h0001: bus.mmio_data_out <= {5'b0, fe, ovr, rxne};
                16'h0002: bus.mmio_data_out <= cdiv_h;
                16'h0003: bus.mmio_data_out <= cdiv_l;
                16'h0004: bus.mmio_data_out <= rxne ? mem[rd_ptr[AW-1:0]] : 8'h00;
                default:  bus.mmio_data_out <= bus.mmio_data_out;
            endcase
        end
    end
endmodule
